// File: rtl/mem_test_initiator.sv
// Write-then-readback test sequencer acting as the sole requester of a
// single-port valid/ready memory; reports mismatches and missing-ready aborts.
module mem_test_initiator #(
  parameter int MEMORY_WIDTH   = 8,
  parameter int MEMORY_DEPTH   = 16,
  parameter int ADDRESS_WIDTH  = $clog2(MEMORY_DEPTH),
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic [ADDRESS_WIDTH-1:0] base_addr_i,
  input  logic [ADDRESS_WIDTH:0]   count_i,
  input  logic [1:0]               mode_i,
  input  logic [MEMORY_WIDTH-1:0]  seed_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [ADDRESS_WIDTH:0]   err_cnt_o,
  output logic [ADDRESS_WIDTH-1:0] first_err_addr_o,
  output logic                     timeout_o,
  output logic [ADDRESS_WIDTH-1:0] addr_o,
  output logic [MEMORY_WIDTH-1:0]  wdata_o,
  output logic                     wr_rd_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  input  logic [MEMORY_WIDTH-1:0]  rdata_i
);

  localparam int CW = ADDRESS_WIDTH + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, DONE} state_e;

  state_e state_q, state_d;

  logic [CW-1:0]            n_q, n_d, k_q, k_d, err_cnt_q, err_cnt_d;
  logic [ADDRESS_WIDTH-1:0] base_q, base_d, addr_q, addr_d, first_err_q, first_err_d;
  logic [1:0]               mode_q, mode_d;
  logic [MEMORY_WIDTH-1:0]  seed_q, seed_d, wdata_q, wdata_d;
  logic                     wr_rd_q, wr_rd_d, busy_q, busy_d, done_q, timeout_q, timeout_d;
  logic [TW-1:0]            tmo_q, tmo_d;

  logic [CW-1:0] count_clamped;
  logic          last_xfer, in_wait, tmo_hit;

  assign count_clamped = (count_i > CW'(MEMORY_DEPTH)) ? CW'(MEMORY_DEPTH) : count_i;
  assign last_xfer     = (k_q + CW'(1)) == n_q;
  assign in_wait       = (state_q == WR_WAIT) || (state_q == RD_WAIT);
  assign tmo_hit       = !ready_i && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

  function automatic logic [MEMORY_WIDTH-1:0] pattern(input logic [1:0]               mode,
                                                      input logic [ADDRESS_WIDTH-1:0] addr,
                                                      input logic [CW-1:0]            idx,
                                                      input logic [MEMORY_WIDTH-1:0]  seed);
    logic [MEMORY_WIDTH-1:0] p;
    case (mode)
      2'd0:    p = MEMORY_WIDTH'(addr);
      2'd1:    p = ~MEMORY_WIDTH'(addr);
      2'd2:    p = seed + MEMORY_WIDTH'(idx);
      default: begin
        for (int i = 0; i < MEMORY_WIDTH; i++) p[i] = ((i % 2) == 0) ^ idx[0];
      end
    endcase
    return p;
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = (count_clamped == '0) ? DONE : WR_REQ;
      WR_REQ:  state_d = WR_WAIT;
      WR_WAIT: begin
        if (ready_i)      state_d = last_xfer ? RD_REQ : WR_REQ;
        else if (tmo_hit) state_d = DONE;
      end
      RD_REQ:  state_d = RD_WAIT;
      RD_WAIT: begin
        if (ready_i)      state_d = last_xfer ? DONE : RD_REQ;
        else if (tmo_hit) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    valid_o = (state_q == WR_REQ) || (state_q == RD_REQ);
  end

  // The read phase compares against wdata_q, which is reloaded with pattern(k) on every request.
  always_comb begin
    n_d         = n_q;
    k_d         = k_q;
    base_d      = base_q;
    mode_d      = mode_q;
    seed_d      = seed_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wr_rd_d     = wr_rd_q;
    err_cnt_d   = err_cnt_q;
    first_err_d = first_err_q;
    timeout_d   = timeout_q;
    busy_d      = busy_q;
    tmo_d       = (in_wait && !ready_i) ? tmo_q + TW'(1) : '0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          n_d         = count_clamped;
          base_d      = base_addr_i;
          mode_d      = mode_i;
          seed_d      = seed_i;
          k_d         = '0;
          err_cnt_d   = '0;
          first_err_d = '0;
          timeout_d   = 1'b0;
          busy_d      = 1'b1;
        end
      end
      WR_WAIT: begin
        if (ready_i)      k_d = last_xfer ? '0 : k_q + CW'(1);
        else if (tmo_hit) timeout_d = 1'b1;
      end
      RD_WAIT: begin
        if (ready_i) begin
          if (rdata_i != wdata_q) begin
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CW'(1);
            if (err_cnt_q == '0) first_err_d = addr_q;
          end
          k_d = k_q + CW'(1);
        end else if (tmo_hit) begin
          timeout_d = 1'b1;
        end
      end
      DONE:    busy_d = 1'b0;
      default: ;
    endcase

    if ((state_d == WR_REQ) || (state_d == RD_REQ)) begin
      addr_d  = base_d + ADDRESS_WIDTH'(k_d);
      wdata_d = pattern(mode_d, addr_d, k_d, seed_d);
      wr_rd_d = (state_d == WR_REQ);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      n_q         <= '0;
      k_q         <= '0;
      base_q      <= '0;
      mode_q      <= '0;
      seed_q      <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wr_rd_q     <= 1'b0;
      err_cnt_q   <= '0;
      first_err_q <= '0;
      timeout_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      tmo_q       <= '0;
    end else begin
      n_q         <= n_d;
      k_q         <= k_d;
      base_q      <= base_d;
      mode_q      <= mode_d;
      seed_q      <= seed_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wr_rd_q     <= wr_rd_d;
      err_cnt_q   <= err_cnt_d;
      first_err_q <= first_err_d;
      timeout_q   <= timeout_d;
      busy_q      <= busy_d;
      done_q      <= (state_q == DONE);
      tmo_q       <= tmo_d;
    end
  end

  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign err_cnt_o        = err_cnt_q;
  assign first_err_addr_o = first_err_q;
  assign timeout_o        = timeout_q;
  assign addr_o           = addr_q;
  assign wdata_o          = wdata_q;
  assign wr_rd_o          = wr_rd_q;

endmodule

// File: tb/tb_mem_test_initiator.sv
// Bench for mem_test_initiator: one-cycle-latency memory responder, request
// monitor and a list-based reference model of each test run.
module tb_mem_test_initiator;

  localparam int MW    = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int CW    = 5;
  localparam int TMO   = 16;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          start_i = 1'b0;
  logic [AW-1:0] base_addr_i = '0;
  logic [CW-1:0] count_i = '0;
  logic [1:0]    mode_i = '0;
  logic [MW-1:0] seed_i = '0;
  logic          busy_o, done_o, timeout_o, wr_rd_o, valid_o;
  logic [CW-1:0] err_cnt_o;
  logic [AW-1:0] first_err_addr_o, addr_o;
  logic [MW-1:0] wdata_o;
  logic          ready_i = 1'b0;
  logic [MW-1:0] rdata_i = '0;

  int assertCount = 0;
  int failCount   = 0;
  int cyc         = 0;

  typedef struct {
    bit wr;
    int addr;
    int data;
  } req_t;

  req_t          reqQ[$];
  logic [MW-1:0] mem [DEPTH];
  logic [MW-1:0] pendData = '0;
  bit            pend = 0, stallAll = 0, corruptEn = 0, corrupted = 0, prevValid = 0;
  int            corruptAddr = 0, b2b = 0, doneCount = 0, doneEdge = 0;

  mem_test_initiator #(
    .MEMORY_WIDTH(MW), .MEMORY_DEPTH(DEPTH), .ADDRESS_WIDTH(AW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .base_addr_i(base_addr_i),
    .count_i(count_i), .mode_i(mode_i), .seed_i(seed_i), .busy_o(busy_o), .done_o(done_o),
    .err_cnt_o(err_cnt_o), .first_err_addr_o(first_err_addr_o), .timeout_o(timeout_o),
    .addr_o(addr_o), .wdata_o(wdata_o), .wr_rd_o(wr_rd_o), .valid_o(valid_o),
    .ready_i(ready_i), .rdata_i(rdata_i)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc++;

  // Responder and monitor run on the falling edge: a request seen here gets its
  // ready one full cycle later, which the DUT samples on the following rising edge.
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      pend      = 0;
      ready_i   = 1'b0;
      prevValid = 0;
    end else begin
      ready_i = pend;
      rdata_i = pendData;
      pend    = 0;
      if (done_o) begin
        doneCount++;
        doneEdge = cyc;
      end
      if (valid_o && prevValid) b2b++;
      prevValid = valid_o;
      if (valid_o) begin
        reqQ.push_back('{wr_rd_o, int'(addr_o), int'(wdata_o)});
        if (!stallAll) begin
          if (wr_rd_o) begin
            mem[addr_o] = wdata_o;
          end else begin
            if (corruptEn && !corrupted) begin
              mem[corruptAddr] = mem[corruptAddr] ^ 8'hFF;
              corrupted = 1;
            end
            pendData = mem[addr_o];
          end
          pend = 1;
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, actual, expected);
    end
  endtask

  function automatic int expData(int mode, int base, int seed, int k);
    int a;
    a = (base + k) % DEPTH;
    case (mode)
      0:       return a;
      1:       return 255 - a;
      2:       return (seed + k) % 256;
      default: return ((k % 2) == 1) ? 'hAA : 'h55;
    endcase
  endfunction

  task automatic applyStimulus(input int base, input int cnt, input int mode, input int seed,
                               input bit corrupt, input int cIdx, input bit stall);
    int n, expReq, expLat, expErr, expFirst, bad, startEdge, doneBefore, k;
    bit seen, expWr;
    n           = (cnt > DEPTH) ? DEPTH : cnt;
    reqQ.delete();
    corrupted   = 0;
    corruptEn   = corrupt && (n > 0) && !stall;
    corruptAddr = (base + cIdx) % DEPTH;
    stallAll    = stall;
    b2b         = 0;

    @(negedge clk_i); #1;
    base_addr_i = AW'(base);
    count_i     = CW'(cnt);
    mode_i      = 2'(mode);
    seed_i      = MW'(seed);
    start_i     = 1'b1;
    doneBefore  = doneCount;
    @(posedge clk_i); #1;
    startEdge = cyc;
    start_i   = 1'b0;
    checkOutput("busy_after_start", busy_o, 1);

    // A second start with different settings mid-run must be ignored.
    seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk_i); #1;
      if (doneCount != doneBefore) seen = 1;
      else if (n > 0 && i == 1) begin
        start_i     = 1'b1;
        base_addr_i = base_addr_i + AW'(3);
        mode_i      = mode_i + 2'd1;
      end else start_i = 1'b0;
    end
    start_i = 1'b0;
    checkOutput("done_seen", seen, 1);

    expLat   = stall ? TMO + 2 : 4 * n + 1;
    expErr   = corruptEn ? 1 : 0;
    expFirst = corruptEn ? corruptAddr : 0;
    expReq   = stall ? 1 : 2 * n;
    checkOutput("done_latency", doneEdge - startEdge, expLat);
    checkOutput("err_cnt", err_cnt_o, expErr);
    checkOutput("first_err_addr", first_err_addr_o, expFirst);
    checkOutput("timeout", timeout_o, stall);
    checkOutput("req_count", reqQ.size(), expReq);

    bad = 0;
    for (int i = 0; i < reqQ.size() && i < expReq; i++) begin
      k     = i % n;
      expWr = (i < n);
      if (reqQ[i].wr != expWr || reqQ[i].addr != (base + k) % DEPTH) bad++;
      else if (expWr && reqQ[i].data != expData(mode, base, seed, k)) bad++;
    end
    checkOutput("req_sequence", bad, 0);
    checkOutput("back_to_back_valid", b2b, 0);

    repeat (2) @(negedge clk_i);
    #1;
    checkOutput("done_single_pulse", doneCount - doneBefore, 1);
    checkOutput("busy_idle", busy_o, 0);
    stallAll = 0;
  endtask

  task automatic resetMidRead();
    bit found;
    int doneBefore, reqBefore;
    @(negedge clk_i); #1;
    reqQ.delete();
    corruptEn   = 0;
    base_addr_i = '0;
    count_i     = CW'(8);
    mode_i      = 2'd0;
    start_i     = 1'b1;
    doneBefore  = doneCount;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    found   = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk_i); #1;
      if (reqQ.size() > 0 && reqQ[reqQ.size() - 1].wr == 0) found = 1;
    end
    checkOutput("read_reached", found, 1);
    @(posedge clk_i); #2;
    rst_ni = 1'b0;
    #1;
    checkOutput("rst_valid", valid_o, 0);
    checkOutput("rst_busy", busy_o, 0);
    checkOutput("rst_done", done_o, 0);
    repeat (2) @(negedge clk_i);
    #1;
    rst_ni    = 1'b1;
    reqBefore = reqQ.size();
    repeat (40) @(negedge clk_i);
    #1;
    checkOutput("rst_no_done", doneCount - doneBefore, 0);
    checkOutput("rst_no_requests", reqQ.size() - reqBefore, 0);
  endtask

  initial begin
    int base, cnt, mode, seed, n, cIdx;
    bit corrupt;
    rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    #1;
    checkOutput("reset_valid", valid_o, 0);
    checkOutput("reset_busy", busy_o, 0);
    checkOutput("reset_done", done_o, 0);
    checkOutput("reset_err_cnt", err_cnt_o, 0);
    checkOutput("reset_first_err", first_err_addr_o, 0);
    checkOutput("reset_timeout", timeout_o, 0);
    checkOutput("reset_addr", addr_o, 0);
    checkOutput("reset_wr_rd", wr_rd_o, 0);
    rst_ni = 1'b1;

    applyStimulus(0, 16, 0, 0, 0, 0, 0);
    applyStimulus(14, 4, 2, 'hF0, 0, 0, 0);
    applyStimulus(0, 8, 0, 0, 1, 5, 0);
    applyStimulus(3, 4, 1, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(2, 20, 3, 0, 0, 0, 0);
    resetMidRead();
    applyStimulus(7, 10, 1, 0, 0, 0, 0);

    for (int r = 0; r < 10; r++) begin
      base    = $urandom_range(0, DEPTH - 1);
      cnt     = $urandom_range(0, 2 * DEPTH - 1);
      mode    = $urandom_range(0, 3);
      seed    = $urandom_range(0, 255);
      corrupt = 1'($urandom_range(0, 1));
      n       = (cnt > DEPTH) ? DEPTH : cnt;
      cIdx    = (n > 0) ? $urandom_range(0, n - 1) : 0;
      applyStimulus(base, cnt, mode, seed, corrupt, cIdx, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
